// File: rtl/tester_reset_sequencer_pkg.sv
// Shared types and constants for the tester reset sequencer.
// Holds FSM states, verdict codes and the counter-width legality check.
package tester_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] VERDICT_NONE    = 2'd0;
    localparam logic [1:0] VERDICT_PASS    = 2'd1;
    localparam logic [1:0] VERDICT_FAIL    = 2'd2;
    localparam logic [1:0] VERDICT_TIMEOUT = 2'd3;

    function automatic bit cnt_w_ok(
        input int cnt_w,
        input int reset_cycles,
        input int timeout_cycles
    );
        longint limit;
        int     m;
        if (cnt_w < 1 || reset_cycles < 1 || timeout_cycles < 1)
            return 1'b0;
        m = (reset_cycles > timeout_cycles) ? reset_cycles : timeout_cycles;
        if (cnt_w >= 32)
            return 1'b1;
        limit = longint'(1) << cnt_w;
        return limit > longint'(m);
    endfunction

endpackage

// File: rtl/tester_reset_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/tester_reset_sequencer.sv
// Drives a tester's reset, then watches finish/fail under a watchdog
// and reports a single pass/fail/timeout verdict.
module tester_reset_sequencer
    import tester_reset_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             dut_reset,
    input  logic             dut_finish,
    input  logic             dut_fail,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    if (!cnt_w_ok(CNT_W, RESET_CYCLES, TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("tester_reset_sequencer: illegal CNT_W/RESET_CYCLES/TIMEOUT_CYCLES");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           next;
    logic             accept;
    logic [1:0]       verdict;
    logic [CNT_W-1:0] hold_count;

    sat_counter #(.W(CNT_W)) u_hold (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state == RESET_HOLD),
        .count  (hold_count)
    );

    // Counting on entry into RUN makes the first RUN cycle read 1.
    sat_counter #(.W(CNT_W)) u_cycle (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (next == RUN),
        .count  (cycle_count)
    );

    always_comb begin
        next    = state;
        accept  = 1'b0;
        verdict = VERDICT_NONE;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    next   = RESET_HOLD;
                    accept = 1'b1;
                end
            end
            RESET_HOLD: begin
                if (hold_count == HOLD_LAST)
                    next = RUN;
            end
            RUN: begin
                if (dut_fail)
                    verdict = VERDICT_FAIL;
                else if (dut_finish)
                    verdict = VERDICT_PASS;
                else if (cycle_count == TIMEOUT_C)
                    verdict = VERDICT_TIMEOUT;
                if (verdict != VERDICT_NONE)
                    next = DONE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            dut_reset <= 1'b1;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= next;
            dut_reset <= (next != RUN);
            if (accept) begin
                pass    <= 1'b0;
                timeout <= 1'b0;
            end else if (verdict == VERDICT_PASS) begin
                pass    <= 1'b1;
            end else if (verdict == VERDICT_TIMEOUT) begin
                timeout <= 1'b1;
            end
        end
    end

    assign busy = (state == RESET_HOLD) || (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tester_reset_sequencer.sv
// Table-driven bench for tester_reset_sequencer with a verdict scoreboard.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_tester_reset_sequencer;

    localparam int RC = 4;
    localparam int TO = 20;
    localparam int W  = 16;

    logic         clock;
    logic         reset;
    logic         start;
    logic         dut_reset;
    logic         dut_finish;
    logic         dut_fail;
    logic         busy;
    logic         done;
    logic         pass;
    logic         timeout;
    logic [W-1:0] cycle_count;

    tester_reset_sequencer #(
        .RESET_CYCLES   (RC),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dut_reset   (dut_reset),
        .dut_finish  (dut_finish),
        .dut_fail    (dut_fail),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    typedef struct {
        int fin;
        int fail;
        bit quirks;
    } vec_t;

    typedef struct {
        bit pass;
        bit timeout;
        int count;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Independent reference: first of fail, finish, watchdog wins; fail beats finish.
    function automatic exp_t model(input int fin, input int fl);
        exp_t e;
        int   f;
        int   x;
        f = (fin == 0) ? 1 << 30 : fin;
        x = (fl == 0) ? 1 << 30 : fl;
        e.pass    = 1'b0;
        e.timeout = 1'b0;
        if (x <= f && x <= TO) begin
            e.count = x;
        end else if (f <= TO) begin
            e.pass  = 1'b1;
            e.count = f;
        end else begin
            e.timeout = 1'b1;
            e.count   = TO;
        end
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   seen;
        int   lat;
        sb.push_back(model(v.fin, v.fail));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clr_pass", pass, 0);
        chk("clr_timeout", timeout, 0);
        chk("clr_done", done, 0);
        for (int i = 0; i < RC; i++) begin
            chk("hold_dut_reset", dut_reset, 1);
            chk("hold_busy", busy, 1);
            dut_finish = v.quirks;
            step();
        end
        dut_finish = 1'b0;
        chk("run_dut_reset", dut_reset, 0);
        chk("run_count1", cycle_count, 1);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 200; k++) begin
            if (done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            dut_finish = (k == v.fin);
            dut_fail   = (k == v.fail);
            start      = v.quirks && (k == 2 || k == 3);
            step();
        end
        dut_finish = 1'b0;
        dut_fail   = 1'b0;
        start      = 1'b0;
        chk("done_seen", seen, 1);
        e = sb.pop_front();
        if (seen) begin
            chk("pass", pass, e.pass);
            chk("timeout", timeout, e.timeout);
            chk("cycle_count", cycle_count, e.count);
            chk("latency", lat, e.count + 1);
            chk("done_dut_reset", dut_reset, 1);
            chk("done_busy", busy, 0);
        end
    endtask

    initial begin
        vecs[0] = '{fin: 10, fail: 0,  quirks: 1'b0};
        vecs[1] = '{fin: 3,  fail: 3,  quirks: 1'b0};
        vecs[2] = '{fin: 0,  fail: 0,  quirks: 1'b0};
        vecs[3] = '{fin: 20, fail: 0,  quirks: 1'b0};
        vecs[4] = '{fin: 0,  fail: 20, quirks: 1'b0};
        vecs[5] = '{fin: 7,  fail: 0,  quirks: 1'b1};
        vecs[6] = '{fin: 1,  fail: 0,  quirks: 1'b0};
        vecs[7] = '{fin: 8,  fail: 5,  quirks: 1'b0};
        vecs[8] = '{fin: 25, fail: 0,  quirks: 1'b0};

        reset      = 1'b1;
        start      = 1'b0;
        dut_finish = 1'b0;
        dut_fail   = 1'b0;
        repeat (3) step();
        chk("rst_dut_reset", dut_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_count", cycle_count, 0);
        reset = 1'b0;
        step();

        dut_finish = 1'b1;
        dut_fail   = 1'b1;
        repeat (3) step();
        chk("idle_ignore_done", done, 0);
        chk("idle_ignore_busy", busy, 0);
        chk("idle_dut_reset", dut_reset, 1);
        dut_finish = 1'b0;
        dut_fail   = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (RC) step();
        repeat (4) step();
        chk("mid_count5", cycle_count, 5);
        reset = 1'b1;
        step();
        chk("mid_dut_reset", dut_reset, 1);
        chk("mid_count", cycle_count, 0);
        chk("mid_done", done, 0);
        chk("mid_busy", busy, 0);
        reset = 1'b0;
        step();
        run_vec('{fin: 9, fail: 0, quirks: 1'b0});

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
